pfi_sym_serializer: RTL and testbench
=====================================

PFI_SYM_SERIALIZER -- requirements
Module: pfi_sym_serializer

Interface
REQ-001 SHALL have parameter LEVEL_W, default 6, meaning the width of the upstream FIFO occupancy count in symbols.
REQ-002 SHALL have port i_core_clk, input, 1, the clock for all logic.
REQ-003 SHALL have port i_rx_rstn, input, 1, an asynchronous active-low reset.
REQ-004 SHALL have port i_fifo_level, input, LEVEL_W, the upstream packing-FIFO occupancy in 6-bit symbols.
REQ-005 SHALL have port i_burst_amt, input, 4, the requested symbols per pop minus 1 (range 1..16 symbols).
REQ-006 SHALL have port o_pop_en, output, 1, the pop strobe to the upstream FIFO.
REQ-007 SHALL have port o_pop_amt, output, 4, the latched pop amount minus 1.
REQ-008 SHALL have port i_pop_data, input, 96, the popped group: symbol k in bits [6k+5:6k], with the oldest symbol at k = o_pop_amt.
REQ-009 SHALL have port o_sym, output, 6, the serial symbol.
REQ-010 SHALL have port o_sym_vld, output, 1, the symbol-valid flag.
REQ-011 SHALL have port i_sym_rdy, input, 1, the downstream-ready flag.
REQ-012 SHALL have port o_busy, output, 1, high whenever the state is not IDLE.
REQ-013 SHALL have port o_sym_cnt, output, 16, the count of accepted symbols, wrapping on overflow.

Function
REQ-014 SHALL implement a state machine with states IDLE, WAIT and SEND.
REQ-015 In IDLE, when i_fifo_level >= i_burst_amt+1 (compared at LEVEL_W+1 bits), SHALL assert o_pop_en for exactly one cycle, latch o_pop_amt=i_burst_amt, and go to WAIT.
REQ-016 In WAIT, SHALL capture i_pop_data into a 96-bit buffer, set index=o_pop_amt, and go to SEND (pop-to-data latency of 1 cycle).
REQ-017 In SEND, SHALL drive o_sym_vld=1 and o_sym=buffer[6*index+5:6*index].
REQ-018 SHALL emit symbols from index o_pop_amt down to 0, oldest first.
REQ-019 SHALL hold o_sym and o_sym_vld stable while i_sym_rdy=0 (no symbol dropped or duplicated).
REQ-020 On a SEND handshake with index>0, SHALL decrement index.
REQ-021 On a SEND handshake with index=0 and the REQ-015 level condition true, SHALL assert o_pop_en in that same cycle, re-latch o_pop_amt, and go to WAIT (back-to-back bursts); otherwise it SHALL go to IDLE.
REQ-022 SHALL not let changes to i_burst_amt after the latch affect the burst in flight.
REQ-023 SHALL never assert o_pop_en outside the IDLE/SEND-final cycles, nor twice without an intervening WAIT.
REQ-024 SHALL increment o_sym_cnt by 1 per o_sym_vld & i_sym_rdy handshake, with 0xFFFF wrapping to 0x0000.
REQ-025 With i_fifo_level=0, SHALL remain in IDLE with o_pop_en=0.

Reset
REQ-026 While i_rx_rstn=0, SHALL force state IDLE and o_pop_en=0, o_pop_amt=0, o_sym=0, o_sym_vld=0, o_busy=0, o_sym_cnt=0, buffer=0 and index=0.
REQ-027 A reset asserted mid-burst SHALL abandon remaining symbols; after release the block SHALL restart from IDLE.

Configuration
REQ-028 With PFI_SYM_PARITY_EN defined, SHALL add output o_sym_par (1 bit) = XOR of o_sym bits, 0 while o_sym_vld=0 and in reset.
REQ-029 Without PFI_SYM_PARITY_EN, the o_sym_par port and its logic SHALL be absent and all other behaviour SHALL be unchanged.

Structure
REQ-030 Shared package pfi_pkg SHALL hold SYM_W=6, MAX_SYM=16, GRP_W=96 and the state enum (IDLE, WAIT, SEND).
REQ-031 Sub-module pfi_sym_sel SHALL be used: a combinational 16:1 symbol mux plus optional parity.

Verification
REQ-032 Level=4, burst_amt=3, rdy=1 SHALL produce: pop at cycle 0 with amt=3; symbols idx3,2,1,0 at cycles 2-5; then IDLE; o_sym_cnt=4.
REQ-033 Level=2, burst_amt=3 SHALL produce no pop; raising level to 4 SHALL produce a pop on the next cycle.
REQ-034 Burst amt=1 with rdy toggling 1,0,0,1 SHALL hold o_sym stable during stalls, give exactly 2 handshakes and no duplicates.
REQ-035 Level held at 16, burst_amt=15 SHALL produce a pop coincident with the idx0 handshake and keep data gap-free except the WAIT cycle.
REQ-036 Reset pulsed at the second symbol of a 4-symbol burst SHALL give all outputs 0 and IDLE, and a fresh burst after release SHALL start at idx3.
REQ-037 With PFI_SYM_PARITY_EN, o_sym=6'b101100 SHALL give o_sym_par=1.

Source files
------------

// File: rtl/pfi_pkg.sv
// Shared constants and state type for the PFI symbol serializer slice.
package pfi_pkg;

  localparam int unsigned SYM_W   = 6;
  localparam int unsigned MAX_SYM = 16;
  localparam int unsigned GRP_W   = 96;
  localparam int unsigned IDX_W   = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SEND
  } state_t;

endpackage

// File: rtl/pfi_sym_sel.sv
// Combinational 16:1 symbol mux with zeroed output when idle.
// Parity output present only when PFI_SYM_PARITY_EN is defined.
module pfi_sym_sel
  import pfi_pkg::*;
(
  input  logic [GRP_W-1:0] grp,
  input  logic [IDX_W-1:0] idx,
  input  logic             vld,
`ifdef PFI_SYM_PARITY_EN
  output logic             par,
`endif
  output logic [SYM_W-1:0] sym
);

  always_comb begin
    sym = '0;
    if (vld) begin
      sym = grp[SYM_W*idx +: SYM_W];
    end
  end

`ifdef PFI_SYM_PARITY_EN
  assign par = ^sym;
`endif

endmodule

// File: rtl/pfi_sym_serializer.sv
// Pops symbol groups from an upstream FIFO and emits them one symbol per handshake, oldest first.
// Optional o_sym_par parity output enabled by PFI_SYM_PARITY_EN.
module pfi_sym_serializer
  import pfi_pkg::*;
#(
  parameter int unsigned LEVEL_W = 6
) (
  input  logic               i_core_clk,
  input  logic               i_rx_rstn,
  input  logic [LEVEL_W-1:0] i_fifo_level,
  input  logic [3:0]         i_burst_amt,
  output logic               o_pop_en,
  output logic [3:0]         o_pop_amt,
  input  logic [GRP_W-1:0]   i_pop_data,
  output logic [SYM_W-1:0]   o_sym,
  output logic               o_sym_vld,
  input  logic               i_sym_rdy,
  output logic               o_busy,
`ifdef PFI_SYM_PARITY_EN
  output logic               o_sym_par,
`endif
  output logic [15:0]        o_sym_cnt
);

  state_t             stateQ, stateD;
  logic [3:0]         popAmtQ;
  logic [GRP_W-1:0]   grpQ;
  logic [IDX_W-1:0]   idxQ;
  logic [15:0]        symCntQ;
  logic [LEVEL_W:0]   needLvl;
  logic               levelOk;
  logic               hsk;
  logic               lastSym;
  logic               popReq;

  assign needLvl = (LEVEL_W+1)'(i_burst_amt) + (LEVEL_W+1)'(1);
  assign levelOk = {1'b0, i_fifo_level} >= needLvl;
  assign hsk     = (stateQ == SEND) && i_sym_rdy;
  assign lastSym = (idxQ == '0);

  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      stateQ <= IDLE;
    end else begin
      stateQ <= stateD;
    end
  end

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      IDLE:    if (levelOk) stateD = WAIT;
      WAIT:    stateD = SEND;
      SEND:    if (hsk && lastSym) stateD = levelOk ? WAIT : IDLE;
      default: stateD = IDLE;
    endcase
  end

  always_comb begin
    popReq = 1'b0;
    unique case (stateQ)
      IDLE:    popReq = levelOk;
      SEND:    popReq = hsk && lastSym && levelOk;
      default: popReq = 1'b0;
    endcase
  end

  // Pop is combinational from IDLE, so it must be masked while reset is held.
  assign o_pop_en  = popReq && i_rx_rstn;
  assign o_pop_amt = o_pop_en ? i_burst_amt : popAmtQ;
  assign o_sym_vld = (stateQ == SEND);
  assign o_busy    = (stateQ != IDLE);
  assign o_sym_cnt = symCntQ;

  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      popAmtQ <= '0;
      grpQ    <= '0;
      idxQ    <= '0;
      symCntQ <= '0;
    end else begin
      if (o_pop_en) begin
        popAmtQ <= i_burst_amt;
      end
      if (stateQ == WAIT) begin
        grpQ <= i_pop_data;
        idxQ <= popAmtQ;
      end else if (hsk && !lastSym) begin
        idxQ <= idxQ - 4'd1;
      end
      if (hsk) begin
        symCntQ <= symCntQ + 16'd1;
      end
    end
  end

  pfi_sym_sel u_sym_sel (
    .grp (grpQ),
    .idx (idxQ),
    .vld (o_sym_vld),
`ifdef PFI_SYM_PARITY_EN
    .par (o_sym_par),
`endif
    .sym (o_sym)
  );

endmodule

// File: tb/tb_pfi_sym_serializer.sv
// Scoreboard bench for pfi_sym_serializer; the bench plays the upstream FIFO.
module tb_pfi_sym_serializer;

  logic        clk = 1'b0;
  logic        rstn;
  logic [5:0]  fifoLevel;
  logic [3:0]  burstAmt;
  logic        popEn;
  logic [3:0]  popAmt;
  logic [95:0] popData;
  logic [5:0]  sym;
  logic        symVld;
  logic        symRdy;
  logic        busy;
  logic [15:0] symCnt;
`ifdef PFI_SYM_PARITY_EN
  logic        symPar;
`endif

  int checks   = 0;
  int failures = 0;
  int hsCount  = 0;

  logic [5:0]  symQ[$];
  logic [5:0]  expSym;
  logic [5:0]  prevSym;
  logic        prevStall;
  logic        popOutstanding;
  logic        popNow;
  logic [95:0] grpData;

  always #5 clk = ~clk;

  pfi_sym_serializer #(.LEVEL_W(6)) dut (
    .i_core_clk   (clk),
    .i_rx_rstn    (rstn),
    .i_fifo_level (fifoLevel),
    .i_burst_amt  (burstAmt),
    .o_pop_en     (popEn),
    .o_pop_amt    (popAmt),
    .i_pop_data   (popData),
    .o_sym        (sym),
    .o_sym_vld    (symVld),
    .i_sym_rdy    (symRdy),
    .o_busy       (busy),
`ifdef PFI_SYM_PARITY_EN
    .o_sym_par    (symPar),
`endif
    .o_sym_cnt    (symCnt)
  );

  // Samples one cycle, runs the scoreboard, then models the FIFO data returned one cycle after a pop.
  task automatic tick();
    #1;
    popNow = popEn;
    if (symVld) popOutstanding = 1'b0;
    if (popEn) begin
      checks++;
      if (popAmt !== burstAmt) begin
        failures++;
        $display("FAIL pop_amt got=%0d exp=%0d", popAmt, burstAmt);
      end
      checks++;
      if (popOutstanding) begin
        failures++;
        $display("FAIL pop_twice got=1 exp=0");
      end
      popOutstanding = 1'b1;
      grpData = {$urandom(), $urandom(), $urandom()};
      for (int k = int'(burstAmt); k >= 0; k--) symQ.push_back(grpData[6*k +: 6]);
    end
    if (symVld && prevStall) begin
      checks++;
      if (sym !== prevSym) begin
        failures++;
        $display("FAIL stall_hold got=%h exp=%h", sym, prevSym);
      end
    end
`ifdef PFI_SYM_PARITY_EN
    checks++;
    if (symPar !== (symVld ? ^sym : 1'b0)) begin
      failures++;
      $display("FAIL parity got=%b sym=%b vld=%b", symPar, sym, symVld);
    end
`endif
    if (symVld && symRdy) begin
      checks++;
      if (symQ.size() == 0) begin
        failures++;
        $display("FAIL sym_extra got=%h exp=none", sym);
      end else begin
        expSym = symQ.pop_front();
        if (sym !== expSym) begin
          failures++;
          $display("FAIL sym_data got=%h exp=%h", sym, expSym);
        end
      end
      hsCount++;
    end
    prevStall = symVld && !symRdy;
    prevSym   = sym;
    @(posedge clk);
    #1;
    popData = popNow ? grpData : {$urandom(), $urandom(), $urandom()};
    @(negedge clk);
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      #1;
      if (!busy && symQ.size() == 0) done = 1'b1;
      else tick();
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL drain_timeout busy=%b queued=%0d exp=idle", busy, symQ.size());
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; fifoLevel = 6'd16; burstAmt = 4'd3; symRdy = 1'b1; popData = '1;
    prevStall = 1'b0; popOutstanding = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({popEn, popAmt, sym, symVld, busy, symCnt} !== '0) begin
      failures++;
      $display("FAIL reset_outs pop=%b amt=%0d sym=%h vld=%b busy=%b cnt=%0d exp=all0",
               popEn, popAmt, sym, symVld, busy, symCnt);
    end
    fifoLevel = 6'd0;
    @(negedge clk);
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    fifoLevel = 6'd4; burstAmt = 4'd3; symRdy = 1'b1;
    #1;
    checks++;
    if (popEn !== 1'b1 || popAmt !== 4'd3) begin
      failures++;
      $display("FAIL basic_pop got=%b/%0d exp=1/3", popEn, popAmt);
    end
    tick();
    fifoLevel = 6'd0; burstAmt = 4'd0;
    #1;
    checks++;
    if (symVld !== 1'b0 || busy !== 1'b1 || popEn !== 1'b0) begin
      failures++;
      $display("FAIL basic_wait vld=%b busy=%b pop=%b exp=0/1/0", symVld, busy, popEn);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (symVld !== 1'b1) begin
        failures++;
        $display("FAIL basic_vld idx=%0d got=%b exp=1", 3 - i, symVld);
      end
      tick();
    end
    #1;
    checks++;
    if (busy !== 1'b0 || symVld !== 1'b0 || symCnt !== 16'd4 || symQ.size() != 0) begin
      failures++;
      $display("FAIL basic_end busy=%b vld=%b cnt=%0d queued=%0d exp=0/0/4/0",
               busy, symVld, symCnt, symQ.size());
    end
  endtask

  task automatic test_level_gate();
    fifoLevel = 6'd0; burstAmt = 4'd3;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (popEn !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL level_zero pop=%b busy=%b exp=0/0", popEn, busy);
      end
      tick();
    end
    for (int lvl = 2; lvl <= 4; lvl++) begin
      fifoLevel = 6'(lvl);
      #1;
      checks++;
      if (popEn !== (lvl == 4)) begin
        failures++;
        $display("FAIL level_gate lvl=%0d got=%b exp=%b", lvl, popEn, lvl == 4);
      end
      tick();
    end
    fifoLevel = 6'd0;
    drain();
  endtask

  task automatic test_stall();
    int hs0;
    logic [3:0] rdyPat = 4'b1001;
    fifoLevel = 6'd2; burstAmt = 4'd1; symRdy = 1'b1;
    hs0 = hsCount;
    tick();
    fifoLevel = 6'd0;
    tick();
    for (int i = 3; i >= 0; i--) begin
      symRdy = rdyPat[i];
      tick();
    end
    symRdy = 1'b1;
    #1;
    checks++;
    if (hsCount - hs0 != 2 || symQ.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL stall_count hs=%0d queued=%0d busy=%b exp=2/0/0",
               hsCount - hs0, symQ.size(), busy);
    end
  endtask

  task automatic test_back_to_back();
    int hs0, pops, gaps, finalPops;
    bit started;
    fifoLevel = 6'd16; burstAmt = 4'd15; symRdy = 1'b1;
    hs0 = hsCount; pops = 0; gaps = 0; finalPops = 0; started = 1'b0;
    for (int i = 0; i < 80 && hsCount - hs0 < 32; i++) begin
      #1;
      if (symVld) started = 1'b1;
      else if (started) gaps++;
      if (symVld && symQ.size() == 1 && popEn) finalPops++;
      if (popEn) pops++;
      tick();
      if (pops == 2) fifoLevel = 6'd0;
    end
    checks++;
    if (hsCount - hs0 != 32 || gaps != 1 || finalPops != 1) begin
      failures++;
      $display("FAIL back_to_back hs=%0d gaps=%0d final_pops=%0d exp=32/1/1",
               hsCount - hs0, gaps, finalPops);
    end
    drain();
  endtask

  task automatic test_midburst_reset();
    fifoLevel = 6'd4; burstAmt = 4'd3; symRdy = 1'b1;
    tick();
    fifoLevel = 6'd0;
    tick();
    tick();
    fifoLevel = 6'd4;
    rstn = 1'b0;
    #1;
    checks++;
    if ({popEn, popAmt, sym, symVld, busy, symCnt} !== '0) begin
      failures++;
      $display("FAIL midreset_outs pop=%b amt=%0d sym=%h vld=%b busy=%b cnt=%0d exp=all0",
               popEn, popAmt, sym, symVld, busy, symCnt);
    end
    symQ.delete();
    prevStall = 1'b0; popOutstanding = 1'b0;
    tick();
    @(negedge clk);
    rstn = 1'b1;
    #1;
    checks++;
    if (popEn !== 1'b1 || popAmt !== 4'd3) begin
      failures++;
      $display("FAIL midreset_restart got=%b/%0d exp=1/3", popEn, popAmt);
    end
    tick();
    fifoLevel = 6'd0;
    drain();
    #1;
    checks++;
    if (symCnt !== 16'd4) begin
      failures++;
      $display("FAIL midreset_cnt got=%0d exp=4", symCnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_level_gate();
    test_stall();
    test_back_to_back();
    test_midburst_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
